// File: rtl/pulse_buf_ctrl.sv
// Sequencer for the BRAM pulse buffer: arms a write, gates one pulse in, waits for readback,
// counts drained beats, and repeats cfg_num_pulses times per run while flagging length/timeout errors.
//
// state   | meaning
// IDLE    | waiting for start
// WAIT_WR | waiting for buffer write_ready
// WRITE   | gating in one pulse of in_size samples
// WAIT_RD | waiting for buffer read_ready
// READ    | counting drained beats until out_tlast
module pulse_buf_ctrl #(
    parameter int LEN_W   = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_num_pulses,
    input  logic             write_ready,
    input  logic             read_ready,
    input  logic [LEN_W-1:0] out_size,
    input  logic             in_tvalid,
    input  logic             in_tready,
    input  logic             in_tlast,
    input  logic             out_tvalid,
    input  logic             out_tready,
    input  logic             out_tlast,
    output logic             init_write,
    output logic [LEN_W-1:0] in_size,
    output logic             in_gate,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic             err_len,
    output logic             err_timeout
);
    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WAIT_WR, WRITE, WAIT_RD, READ} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   in_size_q, in_size_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic               init_write_q, init_write_d;
    logic               in_gate_q, in_gate_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic               err_len_q, err_len_d;
    logic               err_timeout_q, err_timeout_d;
    logic [LEN_W-1:0]   in_beat_q, in_beat_d;
    logic [LEN_W-1:0]   out_beat_q, out_beat_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    logic               in_beat_ev, out_beat_ev, wait_hit;
    logic [LEN_W-1:0]   in_beat_nx, out_beat_nx;
    logic [CNT_W-1:0]   pulse_cnt_nx;
    logic [WAIT_W-1:0]  wait_nx;

    always_comb begin
        in_beat_ev   = in_tvalid & in_tready & in_gate_q;
        out_beat_ev  = out_tvalid & out_tready;
        // Saturating increments: counters never wrap.
        in_beat_nx   = (&in_beat_q)   ? in_beat_q   : in_beat_q + LEN_W'(1);
        out_beat_nx  = (&out_beat_q)  ? out_beat_q  : out_beat_q + LEN_W'(1);
        pulse_cnt_nx = (&pulse_cnt_q) ? pulse_cnt_q : pulse_cnt_q + CNT_W'(1);
        wait_nx      = wait_q + WAIT_W'(1);
        wait_hit     = (TIMEOUT != 0) && (int'(wait_q) + 1 == TIMEOUT);

        state_d       = state_q;
        in_size_d     = in_size_q;
        num_d         = num_q;
        init_write_d  = 1'b0;
        in_gate_d     = 1'b0;
        done_d        = 1'b0;
        pulse_cnt_d   = pulse_cnt_q;
        err_len_d     = err_len_q;
        err_timeout_d = err_timeout_q;
        in_beat_d     = in_beat_q;
        out_beat_d    = out_beat_q;
        wait_d        = wait_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_len != '0 && cfg_num_pulses != '0) begin
                            in_size_d     = cfg_len;
                            num_d         = cfg_num_pulses;
                            err_len_d     = 1'b0;
                            err_timeout_d = 1'b0;
                            pulse_cnt_d   = '0;
                            wait_d        = '0;
                            state_d       = WAIT_WR;
                        end else begin
                            err_len_d = 1'b1;
                        end
                    end
                end
                WAIT_WR: begin
                    if (write_ready) begin
                        init_write_d = 1'b1;
                        in_beat_d    = '0;
                        state_d      = WRITE;
                    end else if (wait_hit) begin
                        err_timeout_d = 1'b1;
                        state_d       = IDLE;
                    end else if (TIMEOUT != 0) begin
                        wait_d = wait_nx;
                    end
                end
                WRITE: begin
                    // Gate opens one cycle after entry, i.e. after the init_write strobe.
                    in_gate_d = 1'b1;
                    if (in_beat_ev) begin
                        in_beat_d = in_beat_nx;
                        if (in_beat_nx == in_size_q) begin
                            in_gate_d = 1'b0;
                            if (in_tlast) begin
                                wait_d  = '0;
                                state_d = WAIT_RD;
                            end else begin
                                err_len_d = 1'b1;
                                state_d   = IDLE;
                            end
                        end else if (in_tlast) begin
                            in_gate_d = 1'b0;
                            err_len_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
                WAIT_RD: begin
                    if (read_ready) begin
                        out_beat_d = '0;
                        state_d    = READ;
                    end else if (wait_hit) begin
                        err_timeout_d = 1'b1;
                        state_d       = IDLE;
                    end else if (TIMEOUT != 0) begin
                        wait_d = wait_nx;
                    end
                end
                READ: begin
                    if (out_beat_ev) begin
                        out_beat_d = out_beat_nx;
                        if (out_tlast) begin
                            if (out_beat_nx != out_size || out_size != in_size_q) begin
                                err_len_d = 1'b1;
                                state_d   = IDLE;
                            end else begin
                                pulse_cnt_d = pulse_cnt_nx;
                                if (pulse_cnt_nx == num_q) begin
                                    done_d  = 1'b1;
                                    state_d = IDLE;
                                end else begin
                                    wait_d  = '0;
                                    state_d = WAIT_WR;
                                end
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            in_size_q     <= '0;
            num_q         <= '0;
            init_write_q  <= 1'b0;
            in_gate_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pulse_cnt_q   <= '0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            in_beat_q     <= '0;
            out_beat_q    <= '0;
            wait_q        <= '0;
        end else begin
            state_q       <= state_d;
            in_size_q     <= in_size_d;
            num_q         <= num_d;
            init_write_q  <= init_write_d;
            in_gate_q     <= in_gate_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pulse_cnt_q   <= pulse_cnt_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
            in_beat_q     <= in_beat_d;
            out_beat_q    <= out_beat_d;
            wait_q        <= wait_d;
        end
    end

    assign init_write  = init_write_q;
    assign in_size     = in_size_q;
    assign in_gate     = in_gate_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulse_cnt   = pulse_cnt_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_pulse_buf_ctrl.sv
// Bench for pulse_buf_ctrl: directed scenarios plus randomized runs checked against a
// run-level model (pulses attempted, beats gated, pulses drained, error flags).
module tb_pulse_buf_ctrl;
    localparam int LEN_W = 32;
    localparam int CNT_W = 16;
    localparam int TMO   = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0, abort = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic [CNT_W-1:0] cfg_num_pulses = '0;
    logic             write_ready = 1'b1, read_ready = 1'b0;
    logic [LEN_W-1:0] out_size = '0;
    logic             in_tvalid = 1'b0, in_tready = 1'b0, in_tlast = 1'b0;
    logic             out_tvalid = 1'b0, out_tready = 1'b0, out_tlast = 1'b0;
    logic             init_write, in_gate, busy, done, err_len, err_timeout;
    logic [LEN_W-1:0] in_size;
    logic [CNT_W-1:0] pulse_cnt;

    int checks = 0;
    int errors = 0;
    int n_init = 0, n_done = 0, n_gated = 0;

    pulse_buf_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_len(cfg_len), .cfg_num_pulses(cfg_num_pulses),
        .write_ready(write_ready), .read_ready(read_ready), .out_size(out_size),
        .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
        .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .init_write(init_write), .in_size(in_size), .in_gate(in_gate), .busy(busy),
        .done(done), .pulse_cnt(pulse_cnt), .err_len(err_len), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init_write) n_init <= n_init + 1;
        if (done) n_done <= n_done + 1;
        if (in_tvalid && in_tready && in_gate) n_gated <= n_gated + 1;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int len, input int num);
        cfg_len = len;
        cfg_num_pulses = num[CNT_W-1:0];
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_init(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (init_write) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    // Upstream source: pushes nbeats accepted beats, tlast on beat tlast_at (0 = never).
    task automatic send_in(input int nbeats, input int tlast_at, input bit rnd, output bit ok);
        int sent = 0;
        int guard = 0;
        bit v, r;
        while (sent < nbeats && guard < 500) begin
            v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_tvalid = v;
            in_tready = r;
            in_tlast  = (sent + 1 == tlast_at);
            if (v && r && in_gate) sent++;
            step();
            guard++;
        end
        in_tvalid = 1'b0;
        in_tready = 1'b0;
        in_tlast  = 1'b0;
        ok = (sent == nbeats);
    endtask

    task automatic send_out(input int nbeats, input int tlast_at, input bit rnd, output bit ok);
        int sent = 0;
        int guard = 0;
        bit v, r;
        while (sent < nbeats && guard < 500) begin
            v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_tvalid = v;
            out_tready = r;
            out_tlast  = (sent + 1 == tlast_at);
            if (v && r) sent++;
            step();
            guard++;
        end
        out_tvalid = 1'b0;
        out_tready = 1'b0;
        out_tlast  = 1'b0;
        ok = (sent == nbeats);
    endtask

    // kind: 0 good, 1 early tlast, 2 missing tlast, 3 out_size short, 4 extra read beat
    task automatic run_pulse(input int len, input int kind, input bit rnd,
                             output int gated, output bit err);
        bit ok;
        int e, osz, nb;
        gated = 0;
        err   = 1'b0;
        wait_init(ok);
        chk("init_write_seen", ok, 1);
        chk("gate_low_during_arm", in_gate, 0);
        step();
        chk("init_write_one_cycle", init_write, 0);
        chk("gate_high_after_arm", in_gate, 1);
        case (kind)
            1: begin
                e = $urandom_range(1, len - 1);
                send_in(e, e, rnd, ok);
                gated = e;
                err = 1'b1;
            end
            2: begin
                send_in(len, 0, rnd, ok);
                gated = len;
                err = 1'b1;
            end
            default: begin
                send_in(len, len, rnd, ok);
                gated = len;
            end
        endcase
        chk("in_beats_sent", ok, 1);
        chk("gate_low_after_write", in_gate, 0);
        if (err) return;
        osz = (kind == 3) ? len - 1 : len;
        out_size = osz;
        read_ready = 1'b1;
        step();
        step();
        read_ready = 1'b0;
        nb = (kind == 4) ? len + 1 : osz;
        send_out(nb, nb, rnd, ok);
        chk("out_beats_sent", ok, 1);
        err = (kind >= 3);
    endtask

    initial begin
        int s_init, s_done, s_gated, g, g_tot, att, exp_pc, len, num, kind, x;
        bit perr, exp_err, ok;

        // Reset state
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_init_write", init_write, 0);
        chk("rst_in_gate", in_gate, 0);
        chk("rst_in_size", in_size, 0);
        chk("rst_pulse_cnt", pulse_cnt, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_err_timeout", err_timeout, 0);
        reset = 1'b1;
        step();

        // Three clean pulses of 10
        s_init = n_init; s_done = n_done; s_gated = n_gated;
        do_start(10, 3);
        chk("t1_busy", busy, 1);
        for (int p = 0; p < 3; p++) run_pulse(10, 0, 1'b0, g, perr);
        chk("t1_done_strobe", done, 1);
        chk("t1_pulse_cnt", pulse_cnt, 3);
        chk("t1_in_size", in_size, 10);
        step();
        chk("t1_done_one_cycle", done, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_init_count", n_init - s_init, 3);
        chk("t1_gated_beats", n_gated - s_gated, 30);
        chk("t1_done_count", n_done - s_done, 1);
        chk("t1_err_len", err_len, 0);
        chk("t1_err_timeout", err_timeout, 0);

        // Early tlast on beat 7 of 10
        s_done = n_done;
        do_start(10, 1);
        wait_init(ok);
        chk("t2_init_seen", ok, 1);
        step();
        send_in(7, 7, 1'b0, ok);
        chk("t2_err_len", err_len, 1);
        chk("t2_busy", busy, 0);
        chk("t2_in_gate", in_gate, 0);
        step();
        chk("t2_done_count", n_done - s_done, 0);

        // Write timeout after TMO cycles in WAIT_WR
        write_ready = 1'b0;
        s_init = n_init;
        do_start(5, 1);
        chk("t3_err_len_cleared", err_len, 0);
        repeat (TMO - 1) step();
        chk("t3_busy_before_tmo", busy, 1);
        chk("t3_no_tmo_yet", err_timeout, 0);
        step();
        chk("t3_err_timeout", err_timeout, 1);
        chk("t3_busy_after_tmo", busy, 0);
        step();
        chk("t3_no_init_write", n_init - s_init, 0);
        write_ready = 1'b1;

        // Abort during READ after 4 of 10 beats
        s_done = n_done;
        do_start(10, 2);
        chk("t4_err_timeout_cleared", err_timeout, 0);
        run_pulse(10, 0, 1'b0, g, perr);
        chk("t4_pc_first", pulse_cnt, 1);
        wait_init(ok);
        step();
        send_in(10, 10, 1'b0, ok);
        out_size = 10;
        read_ready = 1'b1;
        step();
        step();
        read_ready = 1'b0;
        send_out(4, 0, 1'b0, ok);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_busy_after_abort", busy, 0);
        chk("t4_pc_hold", pulse_cnt, 1);
        chk("t4_in_gate", in_gate, 0);
        chk("t4_err_len", err_len, 0);
        do_start(10, 1);
        run_pulse(10, 0, 1'b0, g, perr);
        chk("t4_rerun_pc", pulse_cnt, 1);
        step();
        chk("t4_done_count", n_done - s_done, 1);

        // Zero-field start, abort+start collision, start while busy
        do_start(10, 0);
        chk("t5_zero_busy", busy, 0);
        chk("t5_zero_err_len", err_len, 1);
        abort = 1'b1;
        do_start(4, 1);
        abort = 1'b0;
        chk("t5_abort_wins", busy, 0);
        s_done = n_done;
        do_start(6, 1);
        do_start(3, 5);
        run_pulse(6, 0, 1'b0, g, perr);
        chk("t5_in_size", in_size, 6);
        chk("t5_pc", pulse_cnt, 1);
        chk("t5_err_len_cleared", err_len, 0);
        step();
        chk("t5_done_count", n_done - s_done, 1);

        // Reset mid-WRITE, then out_size mismatch
        do_start(10, 2);
        wait_init(ok);
        step();
        send_in(4, 0, 1'b0, ok);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_in_gate", in_gate, 0);
        chk("t6_rst_in_size", in_size, 0);
        chk("t6_rst_pc", pulse_cnt, 0);
        chk("t6_rst_init_write", init_write, 0);
        step();
        do_start(10, 1);
        run_pulse(10, 3, 1'b0, g, perr);
        chk("t6_size_err_len", err_len, 1);
        chk("t6_size_busy", busy, 0);
        chk("t6_size_pc", pulse_cnt, 0);

        // Randomized runs against the run-level model
        for (int run = 0; run < 25; run++) begin
            len = $urandom_range(2, 12);
            num = $urandom_range(1, 4);
            s_init = n_init; s_done = n_done; s_gated = n_gated;
            do_start(len, num);
            exp_pc = 0; exp_err = 1'b0; att = 0; g_tot = 0;
            for (int p = 0; p < num && !exp_err; p++) begin
                x = $urandom_range(0, 9);
                kind = (x < 6) ? 0 : x - 5;
                att++;
                run_pulse(len, kind, 1'b1, g, perr);
                g_tot += g;
                if (perr) exp_err = 1'b1;
                else exp_pc++;
            end
            step();
            chk("rnd_pulse_cnt", pulse_cnt, exp_pc);
            chk("rnd_err_len", err_len, exp_err);
            chk("rnd_err_timeout", err_timeout, 0);
            chk("rnd_busy", busy, 0);
            chk("rnd_in_size", in_size, len);
            chk("rnd_init_count", n_init - s_init, att);
            chk("rnd_gated_beats", n_gated - s_gated, g_tot);
            chk("rnd_done_count", n_done - s_done, exp_err ? 0 : 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
